// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and line constants for the buffered UART transmitter.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_DATA_BITS    = 8;
  localparam int CLK_FREQ_HZ       = 100_000_000;
  localparam int UART_BAUD         = 57600;
  localparam int UART_CLKS_PER_BIT = CLK_FREQ_HZ / UART_BAUD;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo_if
// Brief   : Byte valid/ready handshake from internal producers to the UART TX.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock first-word-fall-through FIFO, pointers with wrap bit.
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_diff;
  logic             w_wr;
  logic             w_rd;

  // Same index with differing wrap bits means the write side lapped the read side.
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign w_diff  = r_wr_ptr - r_rd_ptr;
  assign count   = CNT_W'(w_diff);
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  assign w_wr = wr_en && !full;
  assign w_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : Buffered 8N1 UART transmitter: byte FIFO feeding a framing FSM.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_fifo_if.slave    s_tx,
  output logic             txd,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int BW   = $clog2(CLKS_PER_BIT);
  localparam int BITW = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0]   c_BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   c_BAUD_ONE = BW'(1);
  localparam logic [BITW-1:0] c_BIT_LAST = BITW'(UART_DATA_BITS - 1);
  localparam logic [BITW-1:0] c_BIT_ONE  = BITW'(1);

  uart_tx_state_t            r_state;
  uart_tx_state_t            w_state_nx;
  logic [BW-1:0]             r_baud;
  logic [BW-1:0]             w_baud_nx;
  logic [BITW-1:0]           r_bit;
  logic [BITW-1:0]           w_bit_nx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_nx;
  logic                      r_txd;
  logic                      w_txd_nx;

  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_bit_end;
  logic [UART_DATA_BITS-1:0] w_rd_data;

  assign w_push         = s_tx.tx_valid && !w_full;
  assign s_tx.tx_ready  = !w_full;
  assign w_bit_end      = (r_baud == c_BAUD_MAX);

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_push),
    .wr_data (s_tx.tx_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (fifo_count)
  );

  // Line level is a function of the current state, so it lands one edge after the transition.
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud + c_BAUD_ONE;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_txd_nx   = 1'b1;
    w_pop      = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nx = '0;
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = w_rd_data;
          w_state_nx = START;
        end
      end
      START: begin
        w_txd_nx = 1'b0;
        if (w_bit_end) begin
          w_baud_nx  = '0;
          w_bit_nx   = '0;
          w_state_nx = DATA;
        end
      end
      DATA: begin
        w_txd_nx = r_shift[0];
        if (w_bit_end) begin
          w_baud_nx  = '0;
          w_shift_nx = {1'b0, r_shift[UART_DATA_BITS-1:1]};
          w_bit_nx   = r_bit + c_BIT_ONE;
          if (r_bit == c_BIT_LAST) begin
            w_state_nx = STOP;
          end
        end
      end
      STOP: begin
        w_txd_nx = 1'b1;
        if (w_bit_end) begin
          w_baud_nx = '0;
          // Chaining straight into START keeps consecutive frames gap-free.
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_shift_nx = w_rd_data;
            w_state_nx = START;
          end else begin
            w_state_nx = IDLE;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_txd   <= w_txd_nx;
    end
  end

  assign txd  = r_txd;
  assign busy = (r_state != IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_fifo
// Brief   : Self-checking bench for uart_tx_fifo with a byte scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int DCPB  = 1736;
  localparam int DLEN  = 10 * DCPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          txd4;
  logic          busy4;
  logic [CW-1:0] cnt4;
  logic          txdd;
  logic          busyd;
  logic [CW-1:0] cntd;

  uart_tx_fifo_if u_if4 ();
  uart_tx_fifo_if u_ifd ();

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut4 (
    .clk        (clk),
    .reset      (rst),
    .s_tx       (u_if4),
    .txd        (txd4),
    .busy       (busy4),
    .fifo_count (cnt4)
  );

  uart_tx_fifo dutd (
    .clk        (clk),
    .reset      (rst),
    .s_tx       (u_ifd),
    .txd        (txdd),
    .busy       (busyd),
    .fifo_count (cntd)
  );

  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] sb_q [$];
  logic       line_d [DLEN];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos >= 9) return 1'b1;
    return b[pos-1];
  endfunction

  // Serial receiver on the CPB=4 line: samples mid-bit and retires scoreboard entries.
  initial begin : g_monitor
    int         m_cnt;
    bit         m_act;
    logic [7:0] m_sh;
    logic [7:0] m_exp;
    m_cnt = 0;
    m_act = 1'b0;
    m_sh  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_act = 1'b0;
      end else if (!m_act) begin
        if (txd4 == 1'b0) begin
          m_act = 1'b1;
          m_cnt = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt >= 6 && m_cnt <= 34 && (m_cnt % 4) == 2) begin
          m_sh = {txd4, m_sh[7:1]};
        end
        if (m_cnt == 38) begin
          chk("rx_stop", 32'(txd4), 32'd1);
          if (sb_q.size() == 0) begin
            chk("rx_unexpected_byte", 32'(m_sh), 32'hFFFF_FFFF);
          end else begin
            m_exp = sb_q.pop_front();
            chk("rx_byte", 32'(m_sh), 32'(m_exp));
          end
          m_act = 1'b0;
        end
      end
    end
  end

  task automatic drain4(input string tag);
    int g;
    g = 0;
    while (busy4 && g < 2000) begin
      tick();
      g++;
    end
    repeat (3) tick();
    chk({tag, "_idle"}, 32'(busy4), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin : g_main
    int         acc;
    int         g;
    int         idx;
    logic [7:0] b;
    logic       rdy;
    logic [7:0] rx;

    u_if4.tx_valid = 1'b0;
    u_if4.tx_data  = '0;
    u_ifd.tx_valid = 1'b0;
    u_ifd.tx_data  = '0;

    // Reset with a producer already presenting data: nothing may be taken.
    rst            = 1'b1;
    u_if4.tx_valid = 1'b1;
    u_if4.tx_data  = 8'hEE;
    repeat (3) tick();
    chk("rst_txd",   32'(txd4),           32'd1);
    chk("rst_ready", 32'(u_if4.tx_ready), 32'd1);
    chk("rst_busy",  32'(busy4),          32'd0);
    chk("rst_count", 32'(cnt4),           32'd0);
    u_if4.tx_valid = 1'b0;
    rst            = 1'b0;
    repeat (2) tick();
    chk("post_rst_txd", 32'(txd4), 32'd1);

    // Single byte 0x42: waveform, latency, busy window.
    u_if4.tx_data  = 8'h42;
    u_if4.tx_valid = 1'b1;
    chk("t1_ready", 32'(u_if4.tx_ready), 32'd1);
    sb_q.push_back(8'h42);
    tick();
    u_if4.tx_valid = 1'b0;
    chk("t1_count_acc", 32'(cnt4), 32'd1);
    tick();
    chk("t1_txd_t1", 32'(txd4), 32'd1);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk($sformatf("t1_line_%0d", i), 32'(txd4), 32'(frame_bit(8'h42, i / 4)));
      if (i == 38) chk("t1_busy_last", 32'(busy4), 32'd1);
      if (i == 39) chk("t1_busy_fall", 32'(busy4), 32'd0);
    end
    drain4("t1");

    // Two bytes back to back: contiguous 80-cycle line.
    u_if4.tx_data  = 8'h55;
    u_if4.tx_valid = 1'b1;
    sb_q.push_back(8'h55);
    tick();
    chk("t2_count_a", 32'(cnt4), 32'd1);
    u_if4.tx_data = 8'hAA;
    sb_q.push_back(8'hAA);
    tick();
    u_if4.tx_valid = 1'b0;
    chk("t2_count_b", 32'(cnt4), 32'd1);
    for (int i = 2; i <= 81; i++) begin
      tick();
      if (i == 41) chk("t2_count_c", 32'(cnt4), 32'd0);
      if (i <= 81 && i >= 2) begin
        idx = i - 2;
        b   = (idx < 40) ? 8'h55 : 8'hAA;
        chk($sformatf("t2_line_%0d", idx), 32'(txd4), 32'(frame_bit(b, (idx % 40) / 4)));
      end
      if (i == 80) chk("t2_busy_last", 32'(busy4), 32'd1);
      if (i == 81) chk("t2_busy_fall", 32'(busy4), 32'd0);
    end
    drain4("t2");

    // Streaming 17 bytes: FIFO fills, ready returns one edge after first stop.
    acc            = 0;
    g              = 0;
    u_if4.tx_data  = 8'h00;
    u_if4.tx_valid = 1'b1;
    while (acc < 17 && g < 100) begin
      rdy = u_if4.tx_ready;
      tick();
      if (rdy) begin
        sb_q.push_back(u_if4.tx_data);
        acc++;
        u_if4.tx_data = 8'(acc);
      end
      g++;
    end
    u_if4.tx_valid = 1'b0;
    chk("t3_accepts",   32'(acc),            32'd17);
    chk("t3_ready_low", 32'(u_if4.tx_ready), 32'd0);
    chk("t3_count",     32'(cnt4),           32'd16);
    repeat (24) tick();
    chk("t3_ready_still_low", 32'(u_if4.tx_ready), 32'd0);
    tick();
    chk("t3_ready_back", 32'(u_if4.tx_ready), 32'd1);
    chk("t3_count_15",   32'(cnt4),           32'd15);
    drain4("t3");

    // Reset during data bit 3 of 0xFF, then a clean 0x0F frame.
    u_if4.tx_data  = 8'hFF;
    u_if4.tx_valid = 1'b1;
    tick();
    u_if4.tx_valid = 1'b0;
    repeat (19) tick();
    chk("t4_bit3_level", 32'(txd4), 32'd1);
    chk("t4_busy_mid",   32'(busy4), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_txd",   32'(txd4),  32'd1);
    chk("t4_count", 32'(cnt4),  32'd0);
    chk("t4_busy",  32'(busy4), 32'd0);
    repeat (3) tick();
    chk("t4_txd_idle", 32'(txd4), 32'd1);
    u_if4.tx_data  = 8'h0F;
    u_if4.tx_valid = 1'b1;
    sb_q.push_back(8'h0F);
    tick();
    u_if4.tx_valid = 1'b0;
    repeat (2) tick();
    chk("t4_start", 32'(txd4), 32'd0);
    drain4("t4");

    // Push and pop on the same edge at 15 entries.
    u_if4.tx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      u_if4.tx_data = 8'(8'h80 + i);
      sb_q.push_back(u_if4.tx_data);
      tick();
    end
    u_if4.tx_valid = 1'b0;
    chk("t6_count_pre", 32'(cnt4), 32'd15);
    repeat (25) tick();
    chk("t6_count_hold", 32'(cnt4), 32'd15);
    u_if4.tx_data  = 8'hC3;
    u_if4.tx_valid = 1'b1;
    chk("t6_ready_pre", 32'(u_if4.tx_ready), 32'd1);
    sb_q.push_back(8'hC3);
    tick();
    u_if4.tx_valid = 1'b0;
    chk("t6_count_same", 32'(cnt4),           32'd15);
    chk("t6_ready_same", 32'(u_if4.tx_ready), 32'd1);
    drain4("t6");

    // Default baud: 0x0A on the full-rate instance, decoded from a captured line.
    u_ifd.tx_data  = 8'h0A;
    u_ifd.tx_valid = 1'b1;
    tick();
    u_ifd.tx_valid = 1'b0;
    g = 0;
    while (txdd && g < 10) begin
      tick();
      g++;
    end
    chk("t5_start_seen", 32'(g), 32'd2);
    line_d[0] = txdd;
    for (int j = 1; j < DLEN; j++) begin
      tick();
      line_d[j] = txdd;
    end
    for (int k = 0; k < 8; k++) begin
      rx[k] = line_d[DCPB * (k + 1) + DCPB / 2];
    end
    chk("t5_start_mid", 32'(line_d[DCPB / 2]),          32'd0);
    chk("t5_byte",      32'(rx),                        32'h0A);
    chk("t5_stop",      32'(line_d[9 * DCPB + DCPB / 2]), 32'd1);
    chk("t5_d0_end",    32'(line_d[2 * DCPB - 1]),      32'd0);
    chk("t5_d1_begin",  32'(line_d[2 * DCPB]),          32'd1);
    chk("t5_d1_end",    32'(line_d[3 * DCPB - 1]),      32'd1);
    chk("t5_d2_begin",  32'(line_d[3 * DCPB]),          32'd0);
    chk("t5_busy_end",  32'(busyd),                     32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin : g_watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
